bus_reg_writer: RTL and testbench

//   Write side of the processor's 16-bit internal bus. The read mux drives one register onto the
//   bus; this block takes the bus value plus a 4-bit destination code and loads it into the

---
 rtl/bus_reg_writer.sv | 97 +++++++++
 tb/tb_bus_reg_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_writer.sv
// Bus write side: decodes wr_sel and loads bus_in into one of nine registers (1-cycle latency).
// No backpressure; PC increment, AC clear and a sticky illegal-destination flag ride alongside.
module bus_reg_writer #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             inc_pc,
  input  logic             clr_ac,
  input  logic             err_clr,
  output logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] RA,
  output logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] RC,
  output logic [WIDTH-1:0] AC,
  output logic [WIDTH-1:0] PC,
  output logic             wr_ack,
  output logic             sel_err
);

  // Bits 0..6 follow codes 0000..0110 directly (RA,RB,RC,R1,R2,R3,DR); bit 7 = AC, bit 8 = PC.
  logic [8:0]       w_we;
  logic             w_legal;
  logic             w_illegal;
  logic [WIDTH-1:0] r_gp [7];
  logic [WIDTH-1:0] r_ac;
  logic [WIDTH-1:0] r_pc;
  logic             r_wr_ack;
  logic             r_sel_err;

  always_comb begin
    w_we = '0;
    case (wr_sel)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: w_we[wr_sel[2:0]] = wr_en;
      4'd9:    w_we[7] = wr_en;
      4'd10:   w_we[8] = wr_en;
      default: ;
    endcase
  end

  assign w_legal   = |w_we;
  assign w_illegal = wr_en & ~w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) r_gp[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (w_we[i]) r_gp[i] <= bus_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ac <= '0;
    else if (w_we[7]) r_ac <= bus_in;
    else if (clr_ac)  r_ac <= '0;
  end

  // Increment wraps silently at the top of the range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pc <= PC_RESET;
    else if (w_we[8]) r_pc <= bus_in;
    else if (inc_pc)  r_pc <= r_pc + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ack  <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_wr_ack <= w_legal;
      if (w_illegal)    r_sel_err <= 1'b1;
      else if (err_clr) r_sel_err <= 1'b0;
    end
  end

  assign RA      = r_gp[0];
  assign RB      = r_gp[1];
  assign RC      = r_gp[2];
  assign R1      = r_gp[3];
  assign R2      = r_gp[4];
  assign R3      = r_gp[5];
  assign DR      = r_gp[6];
  assign AC      = r_ac;
  assign PC      = r_pc;
  assign wr_ack  = r_wr_ack;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_bus_reg_writer.sv
// Directed bench for bus_reg_writer: reset, per-code writes, illegal codes, PC/AC side ops, async reset.
module tb_bus_reg_writer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] bus_in;
  logic        inc_pc;
  logic        clr_ac;
  logic        err_clr;
  logic [15:0] DR, R1, R2, R3, RA, RB, RC, AC, PC;
  logic        wr_ack;
  logic        sel_err;

  int n_cmp = 0;
  int n_err = 0;

  // Expected register contents, order: RA RB RC R1 R2 R3 DR AC PC
  logic [15:0] exp_r [9];
  logic [3:0]  codes [9];

  bus_reg_writer #(.WIDTH(16), .PC_RESET(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .bus_in(bus_in),
    .inc_pc(inc_pc), .clr_ac(clr_ac), .err_clr(err_clr),
    .DR(DR), .R1(R1), .R2(R2), .R3(R3), .RA(RA), .RB(RB), .RC(RC), .AC(AC), .PC(PC),
    .wr_ack(wr_ack), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " RA"}, RA, exp_r[0]);
    chk({tag, " RB"}, RB, exp_r[1]);
    chk({tag, " RC"}, RC, exp_r[2]);
    chk({tag, " R1"}, R1, exp_r[3]);
    chk({tag, " R2"}, R2, exp_r[4]);
    chk({tag, " R3"}, R3, exp_r[5]);
    chk({tag, " DR"}, DR, exp_r[6]);
    chk({tag, " AC"}, AC, exp_r[7]);
    chk({tag, " PC"}, PC, exp_r[8]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    exp_r[8] = 16'h0010;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 4'h0; bus_in = 16'h0000;
    inc_pc = 1'b0; clr_ac = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
    codes[3] = 4'b0011; codes[4] = 4'b0100; codes[5] = 4'b0101;
    codes[6] = 4'b0110; codes[7] = 4'b1001; codes[8] = 4'b1010;
    idle();
    rst_n = 1'b0;
    reset_model();

    // 1. reset state
    #23;
    chk_all("reset");
    chk("reset wr_ack", {15'd0, wr_ack}, 16'd0);
    chk("reset sel_err", {15'd0, sel_err}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk_all("post-reset idle");

    // 2. A5A5 to each legal code in turn, back to back
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_sel = codes[i]; bus_in = 16'hA5A5;
      tick();
      exp_r[i] = 16'hA5A5;
      chk_all($sformatf("write code %b", codes[i]));
      chk($sformatf("wr_ack code %b", codes[i]), {15'd0, wr_ack}, 16'd1);
    end
    idle();
    tick();
    chk("wr_ack after idle", {15'd0, wr_ack}, 16'd0);
    chk_all("hold after writes");

    // 3. illegal code, sticky flag, clear, set-wins
    wr_en = 1'b1; wr_sel = 4'b0111; bus_in = 16'h1234;
    tick();
    chk_all("illegal 0111");
    chk("illegal wr_ack", {15'd0, wr_ack}, 16'd0);
    chk("illegal sel_err", {15'd0, sel_err}, 16'd1);
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sel_err sticky %0d", i), {15'd0, sel_err}, 16'd1);
    end
    err_clr = 1'b1;
    tick();
    chk("sel_err cleared", {15'd0, sel_err}, 16'd0);
    wr_en = 1'b1; wr_sel = 4'b1111; bus_in = 16'h5555;
    tick();
    chk("sel_err set wins", {15'd0, sel_err}, 16'd1);
    chk_all("illegal 1111");
    wr_sel = 4'b1000; err_clr = 1'b0;
    tick();
    chk_all("illegal 1000");
    chk("illegal 1000 wr_ack", {15'd0, wr_ack}, 16'd0);
    idle();
    err_clr = 1'b1;
    tick();
    idle();

    // 4. PC wrap and write-over-increment
    wr_en = 1'b1; wr_sel = 4'b1010; bus_in = 16'hFFFF;
    tick();
    exp_r[8] = 16'hFFFF;
    chk("PC load FFFF", PC, exp_r[8]);
    idle();
    inc_pc = 1'b1;
    tick();
    chk("PC wrap", PC, 16'h0000);
    chk("inc wr_ack", {15'd0, wr_ack}, 16'd0);
    wr_en = 1'b1; wr_sel = 4'b1010; bus_in = 16'h0200;
    tick();
    exp_r[8] = 16'h0200;
    chk("PC write beats inc", PC, exp_r[8]);
    chk("PC write wr_ack", {15'd0, wr_ack}, 16'd1);
    idle();

    // 5. AC clear vs write, then inc_pc + clr_ac together
    wr_en = 1'b1; wr_sel = 4'b1001; bus_in = 16'h00FF;
    tick();
    clr_ac = 1'b1; bus_in = 16'h0042;
    tick();
    exp_r[7] = 16'h0042;
    chk("AC write beats clr", AC, exp_r[7]);
    idle();
    clr_ac = 1'b1;
    tick();
    exp_r[7] = 16'h0000;
    chk("AC clr", AC, exp_r[7]);
    clr_ac = 1'b0; wr_en = 1'b1; wr_sel = 4'b1001; bus_in = 16'h7777;
    tick();
    idle();
    inc_pc = 1'b1; clr_ac = 1'b1;
    tick();
    exp_r[8] = 16'h0201;
    chk_all("inc_pc+clr_ac");
    idle();

    // 6. async reset between edges
    wr_en = 1'b1; wr_sel = 4'b0100; bus_in = 16'hBEEF;
    tick();
    exp_r[4] = 16'hBEEF;
    chk("R2 BEEF", R2, exp_r[4]);
    wr_en = 1'b1; wr_sel = 4'b0100; bus_in = 16'h1111;
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    chk_all("async reset");
    tick();
    chk_all("write during reset");
    chk("reset wr_ack hold", {15'd0, wr_ack}, 16'd0);
    idle();
    #2;
    rst_n = 1'b1;
    tick();
    chk_all("after reset release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
